// File: rtl/ballot_pkg.sv
// Shared types and constants for the ballot box tally slice.
package ballot_pkg;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_CLOSED  = 2'd2
  } state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Index width for n distinct values; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ballot_box_tally_sat_counter.sv
// Saturating up-counter; ovf flags an increment attempted while already at maximum.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         ovf
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc && (count_reg != MAX)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;
  assign ovf   = inc && (count_reg == MAX);

endmodule

// File: rtl/ballot_box_tally.sv
// Ballot box: BCD keypad entry, candidate ID match, confirm/correct and saturating tallies.
// Optional blank-vote key enabled by defining BALLOT_BLANK_VOTE_EN.
module ballot_box_tally
  import ballot_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_CAND   = 4,
  parameter int CNT_W      = 8,
  parameter logic [NUM_CAND*NUM_DIGITS*4-1:0] CAND_IDS =
    {16'h3480, 16'h3489, 16'h3513, 16'h3503}
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        digit_valid,
  input  logic [3:0]                  digit,
  input  logic                        confirm,
  input  logic                        correct,
  input  logic                        finish,
`ifdef BALLOT_BLANK_VOTE_EN
  input  logic                        blank,
  output logic [CNT_W-1:0]            blank_count,
  output logic [idx_w(NUM_CAND+2)-1:0] vote_idx,
`else
  output logic [idx_w(NUM_CAND+1)-1:0] vote_idx,
`endif
  output logic [NUM_DIGITS*4-1:0]     entry,
  output logic [1:0]                  state,
  output logic                        vote_pulse,
  output logic [NUM_CAND*CNT_W-1:0]   tally,
  output logic [CNT_W-1:0]            null_count,
  output logic                        overflow
);

  localparam int ID_W = NUM_DIGITS * BCD_W;
  localparam int DC_W = idx_w(NUM_DIGITS);
`ifdef BALLOT_BLANK_VOTE_EN
  localparam int VI_W  = idx_w(NUM_CAND + 2);
  localparam int N_OVF = NUM_CAND + 2;
`else
  localparam int VI_W  = idx_w(NUM_CAND + 1);
  localparam int N_OVF = NUM_CAND + 1;
`endif

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   entry_reg, entry_next;
  logic [DC_W-1:0]   digit_cnt_reg, digit_cnt_next;
  logic              vote_pulse_reg, vote_pulse_next;
  logic [VI_W-1:0]   vote_idx_reg, vote_idx_next;
  logic              overflow_reg;

  logic [NUM_CAND-1:0] match;
  logic [NUM_CAND-1:0] first_hot;
  logic                hit;
  logic [VI_W-1:0]     hit_idx;
  logic [NUM_CAND-1:0] cand_inc;
  logic                null_inc;
  logic [N_OVF-1:0]    ovf_vec;

  generate
    for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_match
      assign match[gi] = (entry_reg == CAND_IDS[gi*ID_W +: ID_W]);
    end
  endgenerate

  // Lowest matching index wins when several table entries share an ID.
  assign first_hot = match & (~match + NUM_CAND'(1));
  assign hit       = |match;

  always_comb begin
    hit_idx = VI_W'(NUM_CAND);
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = VI_W'(i);
    end
  end

`ifdef BALLOT_BLANK_VOTE_EN
  logic blank_flag_reg, blank_flag_next;
  logic blank_inc;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_ENTRY;
      entry_reg      <= '0;
      digit_cnt_reg  <= '0;
      vote_pulse_reg <= 1'b0;
      vote_idx_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      entry_reg      <= entry_next;
      digit_cnt_reg  <= digit_cnt_next;
      vote_pulse_reg <= vote_pulse_next;
      vote_idx_reg   <= vote_idx_next;
    end
  end

`ifdef BALLOT_BLANK_VOTE_EN
  always_ff @(posedge clock) begin
    if (reset) blank_flag_reg <= 1'b0;
    else       blank_flag_reg <= blank_flag_next;
  end
`endif

  always_comb begin
    state_next      = state_reg;
    entry_next      = entry_reg;
    digit_cnt_next  = digit_cnt_reg;
    vote_pulse_next = 1'b0;
    vote_idx_next   = vote_idx_reg;
    cand_inc        = '0;
    null_inc        = 1'b0;
`ifdef BALLOT_BLANK_VOTE_EN
    blank_flag_next = blank_flag_reg;
    blank_inc       = 1'b0;
`endif
    case (state_reg)
      ST_ENTRY, ST_CONFIRM: begin
        if (finish || correct) begin
          state_next     = finish ? ST_CLOSED : ST_ENTRY;
          entry_next     = '0;
          digit_cnt_next = '0;
`ifdef BALLOT_BLANK_VOTE_EN
          blank_flag_next = 1'b0;
`endif
        end else if (state_reg == ST_CONFIRM) begin
          if (confirm) begin
            state_next      = ST_ENTRY;
            entry_next      = '0;
            digit_cnt_next  = '0;
            vote_pulse_next = 1'b1;
`ifdef BALLOT_BLANK_VOTE_EN
            blank_flag_next = 1'b0;
            if (blank_flag_reg) begin
              blank_inc     = 1'b1;
              vote_idx_next = VI_W'(NUM_CAND + 1);
            end else
`endif
            begin
              cand_inc      = first_hot;
              null_inc      = ~hit;
              vote_idx_next = hit_idx;
            end
          end
        end else begin
`ifdef BALLOT_BLANK_VOTE_EN
          if (blank && (digit_cnt_reg == '0)) begin
            state_next      = ST_CONFIRM;
            entry_next      = '0;
            blank_flag_next = 1'b1;
          end else
`endif
          if (digit_valid && (digit <= BCD_MAX)) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (digit_cnt_reg == DC_W'(i))
                entry_next[(NUM_DIGITS-1-i)*BCD_W +: BCD_W] = digit;
            end
            if (digit_cnt_reg == DC_W'(NUM_DIGITS - 1)) begin
              state_next     = ST_CONFIRM;
              digit_cnt_next = '0;
            end else begin
              digit_cnt_next = digit_cnt_reg + DC_W'(1);
            end
          end
        end
      end
      ST_CLOSED: begin
        entry_next     = '0;
        digit_cnt_next = '0;
      end
      default: begin
        state_next     = ST_ENTRY;
        entry_next     = '0;
        digit_cnt_next = '0;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_tally
      sat_counter #(.W(CNT_W)) u_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (cand_inc[gi]),
        .count (tally[gi*CNT_W +: CNT_W]),
        .ovf   (ovf_vec[gi])
      );
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_null (
    .clock (clock),
    .reset (reset),
    .inc   (null_inc),
    .count (null_count),
    .ovf   (ovf_vec[NUM_CAND])
  );

`ifdef BALLOT_BLANK_VOTE_EN
  sat_counter #(.W(CNT_W)) u_blank (
    .clock (clock),
    .reset (reset),
    .inc   (blank_inc),
    .count (blank_count),
    .ovf   (ovf_vec[NUM_CAND+1])
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) overflow_reg <= 1'b0;
    else       overflow_reg <= overflow_reg | (|ovf_vec);
  end

  assign entry      = entry_reg;
  assign state      = state_reg;
  assign vote_pulse = vote_pulse_reg;
  assign vote_idx   = vote_idx_reg;
  assign overflow   = overflow_reg;

endmodule
